dl_sequencer: RTL and testbench
===============================

Name: dl_sequencer

Overview:
- Sits between hps_io's ioctl download stream and the game core in the arcade top level.
- Routes index-0 bytes into the core's ROM write port through a small FIFO, and applies backpressure with ioctl_wait when the ROM port stalls.
- Latches the title number (index 1) and the DIP bytes (index 254), and maps the DIP bytes to a 24-bit DSW word per title.
- Sequences the core reset: held through download and drain, then released after a fixed hold time.

Parameters:
- ROM_AW, 17: ROM write address width. Bytes with ioctl_addr >= 2**ROM_AW are dropped.
- FIFO_DEPTH, 4: ROM write FIFO entries; power of 2, >= 2.
- RST_HOLD, 256: clk_sys cycles core_reset stays high after drain completes; >= 1.

Ports:
- clk_sys  in  1  system clock (48 MHz)
- rst_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  download in progress
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- ioctl_index  in  8  0=ROM, 1=title, 254=DIP
- ioctl_wait  out  1  backpressure to hps_io
- rom_wr_en  out  1  ROM write valid
- rom_wr_addr  out  ROM_AW  ROM write address
- rom_wr_data  out  8  ROM write data
- rom_wr_ready  in  1  ROM port accepts; transfer = rom_wr_en & rom_wr_ready
- tno  out  4  title number
- dsw  out  24  mapped DIP word
- core_reset  out  1  active-high reset to game core
- load_done  out  1  high in RUN
- err_overrun  out  1  sticky: a ROM byte was dropped because the FIFO was full

Behaviour:
- Reset (async, rst_n=0):
  - State = HOLD, hold counter = RST_HOLD-1, FIFO empty.
  - tno=0, all 8 sw bytes = 0.
  - core_reset=1, ioctl_wait=0, rom_wr_en=0, load_done=0, err_overrun=0.
- FSM states: IDLE (unused after reset, same as RUN), LOAD, DRAIN, HOLD, RUN. Transitions:
  - Any state → LOAD when ioctl_download=1. On entry, clear err_overrun and flush the FIFO.
  - LOAD → DRAIN when ioctl_download=0.
  - DRAIN → HOLD when the FIFO is empty, including the same cycle the last entry transfers. Reload the counter with RST_HOLD-1.
  - HOLD: decrement the counter each cycle. HOLD → RUN at count 0.
- Outputs by state:
  - core_reset = 1 in LOAD/DRAIN/HOLD, 0 in RUN. Registered, so it changes one cycle after the state change.
  - load_done = (state==RUN).
- ROM path, on ioctl_wr & ioctl_index==0 & addr in range:
  - Push {addr[ROM_AW-1:0], data}.
  - If the FIFO is full and no pop happens that cycle, drop the byte and set err_overrun.
  - Push and pop in the same cycle while full is legal: count unchanged, nothing dropped.
- FIFO output:
  - rom_wr_en = !empty, with data/addr taken from the head. First-word latency: 1 cycle from push to rom_wr_en.
  - Pop on rom_wr_en & rom_wr_ready. Order preserved.
- ioctl_wait: registered, = (count >= FIFO_DEPTH-1) after the update. This gives hps_io one cycle of slack.
- Pushes are accepted only in LOAD. ioctl_wr outside LOAD is ignored for all indices.
- Title byte: on ioctl_wr & index==1, tno <= dout[3:0]. Last write wins.
- DIP bytes: on ioctl_wr & index==254 & addr[24:3]==0, sw[addr[2:0]] <= dout.
- DSW mapping (combinational from registers):
  - tno 1 or 3: {sw1[3:0], sw2[3:0], sw1, sw0}
  - tno 2: {sw2[3:0], sw2[3:0], sw1, sw0}
  - else: {sw2, sw1, sw0}
- Re-download: a new ioctl_download=1 during HOLD or RUN restarts LOAD. The counter is abandoned and core_reset asserts next cycle. tno and sw persist unless rewritten.
- rst_n asserting mid-transfer aborts everything. rom_wr_en drops immediately (async).

Decomposition:
- Package dl_seq_pkg:
  - state enum {IDLE, LOAD, DRAIN, HOLD, RUN}
  - index constants IDX_ROM=0, IDX_TNO=1, IDX_DIP=254
  - function map_dsw(tno, sw0, sw1, sw2) returning 24 bits
- Sub-module dl_seq_fifo: synchronous FIFO with FIFO_DEPTH entries, ROM_AW+8 bits wide, and push/pop/full/empty/count ports. Registers only; no RAM inference required.

Test Plan:
- Reset release with no download → core_reset=1 for exactly RST_HOLD cycles, then 0 and load_done=1. tno=0, dsw=0.
- Download 16 index-0 bytes (addr 0..15, data = addr^8'hA5) with rom_wr_ready=1 → 16 writes in order with matching addr/data, ioctl_wait never high, err_overrun=0. core_reset falls RST_HOLD cycles after the last write.
- Same stream with rom_wr_ready held low for 10 cycles → ioctl_wait rises when 3 entries are buffered. A bench honouring wait loses no bytes. Then force one extra ioctl_wr while full → err_overrun=1, that byte is never written, and the other bytes stay in order.
- Index 1 writes 8'h03, then index 254 writes sw0=11, sw1=22, sw2=33 → dsw=24'h232211. With tno rewritten to 2, dsw=24'h332211. With tno 0, dsw=24'h332211.
- Byte at addr 2**ROM_AW, and an index-254 write at addr 8 → no ROM write, no sw change.
- ioctl_download re-asserted in HOLD at count 100 → core_reset stays 1, state goes LOAD, err_overrun cleared. After download ends and drain completes, a full RST_HOLD count follows.

Source files
------------

// File: rtl/dl_seq_pkg.sv
// rtl/dl_seq_pkg.sv - shared types, ioctl index codes and DSW mapping for the download sequencer
package dl_seq_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, HOLD, RUN} state_e;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_TNO = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    // Titles 1 and 3 fold nibbles of sw1/sw2 into the top byte; title 2 repeats sw2's low nibble.
    function automatic logic [23:0] map_dsw(input logic [3:0] tno, input logic [7:0] sw0,
                                            input logic [7:0] sw1, input logic [7:0] sw2);
        case (tno)
            4'd1, 4'd3: return {sw1[3:0], sw2[3:0], sw1, sw0};
            4'd2:       return {sw2[3:0], sw2[3:0], sw1, sw0};
            default:    return {sw2, sw1, sw0};
        endcase
    endfunction

endpackage

// File: rtl/dl_sequencer_if.sv
// rtl/dl_sequencer_if.sv - ioctl download, ROM write port and status bundle
interface dl_sequencer_if #(parameter int ROM_AW = 17);
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [7:0]        ioctl_index;
    logic              ioctl_wait;
    logic              rom_wr_en;
    logic [ROM_AW-1:0] rom_wr_addr;
    logic [7:0]        rom_wr_data;
    logic              rom_wr_ready;
    logic [3:0]        tno;
    logic [23:0]       dsw;
    logic              core_reset;
    logic              load_done;
    logic              err_overrun;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, rom_wr_ready,
        input  ioctl_wait, rom_wr_en, rom_wr_addr, rom_wr_data, tno, dsw, core_reset,
               load_done, err_overrun
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, rom_wr_ready,
        output ioctl_wait, rom_wr_en, rom_wr_addr, rom_wr_data, tno, dsw, core_reset,
               load_done, err_overrun
    );
endinterface

// File: rtl/dl_seq_fifo.sv
// rtl/dl_seq_fifo.sv - small register-based FIFO for buffered ROM writes
module dl_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 25
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q;
    logic          do_push, do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= wdata;
    end

    assign rdata = mem_q[rd_q];
    assign full  = (cnt_q == (PW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
endmodule

// File: rtl/dl_sequencer.sv
// rtl/dl_sequencer.sv - routes ioctl download bytes to ROM/title/DIP and sequences core reset
module dl_sequencer
    import dl_seq_pkg::*;
#(
    parameter int ROM_AW     = 17,
    parameter int FIFO_DEPTH = 4,
    parameter int RST_HOLD   = 256
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    dl_sequencer_if.slave  bus
);
    localparam int W  = ROM_AW + 8;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    state_e        state_q;
    logic [CW-1:0] hold_q;
    logic          core_reset_q, err_q;
    logic [3:0]    tno_q;
    logic [7:0]    sw0_q, sw1_q, sw2_q;

    logic          in_load, flush, push_req, pop, drop, drain_done, full, empty;
    logic [PW:0]   count;
    logic [W-1:0]  head;

    assign in_load    = (state_q == LOAD);
    assign flush      = bus.ioctl_download & ~in_load;
    assign push_req   = in_load & bus.ioctl_wr & (bus.ioctl_index == IDX_ROM)
                      & (bus.ioctl_addr[24:ROM_AW] == '0);
    assign pop        = ~empty & bus.rom_wr_ready;
    assign drop       = push_req & full & ~pop;
    assign drain_done = empty | (pop & (count == (PW+1)'(1)));

    dl_seq_fifo #(.DEPTH(FIFO_DEPTH), .W(W)) u_fifo (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push_req),
        .pop   (pop),
        .wdata ({bus.ioctl_addr[ROM_AW-1:0], bus.ioctl_dout}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HOLD;
            hold_q       <= CW'(RST_HOLD - 1);
            core_reset_q <= 1'b1;
            err_q        <= 1'b0;
            tno_q        <= '0;
            sw0_q        <= '0;
            sw1_q        <= '0;
            sw2_q        <= '0;
        end else begin
            core_reset_q <= !(state_q == RUN || state_q == IDLE);
            case (state_q)
                LOAD:    if (!bus.ioctl_download) state_q <= DRAIN;
                DRAIN:   if (drain_done) begin
                             state_q <= HOLD;
                             hold_q  <= CW'(RST_HOLD - 1);
                         end
                HOLD:    if (hold_q == '0) state_q <= RUN;
                         else              hold_q  <= hold_q - 1'b1;
                default: ;
            endcase
            // A new download pre-empts every state, abandoning any hold count in progress.
            if (bus.ioctl_download) state_q <= LOAD;

            if (flush)     err_q <= 1'b0;
            else if (drop) err_q <= 1'b1;

            if (in_load && bus.ioctl_wr && bus.ioctl_index == IDX_TNO)
                tno_q <= bus.ioctl_dout[3:0];
            // Only sw0..sw2 feed the DSW map, so the upper DIP bytes are not stored.
            if (in_load && bus.ioctl_wr && bus.ioctl_index == IDX_DIP && bus.ioctl_addr[24:3] == '0) begin
                case (bus.ioctl_addr[2:0])
                    3'd0:    sw0_q <= bus.ioctl_dout;
                    3'd1:    sw1_q <= bus.ioctl_dout;
                    3'd2:    sw2_q <= bus.ioctl_dout;
                    default: ;
                endcase
            end
        end
    end

    assign bus.ioctl_wait  = (count >= (PW+1)'(FIFO_DEPTH - 1));
    assign bus.rom_wr_en   = ~empty;
    assign bus.rom_wr_addr = head[W-1:8];
    assign bus.rom_wr_data = head[7:0];
    assign bus.tno         = tno_q;
    assign bus.dsw         = map_dsw(tno_q, sw0_q, sw1_q, sw2_q);
    assign bus.core_reset  = core_reset_q;
    assign bus.load_done   = (state_q == RUN);
    assign bus.err_overrun = err_q;
endmodule

// File: tb/tb_dl_sequencer.sv
// tb/tb_dl_sequencer.sv - directed self-checking bench for dl_sequencer
module tb_dl_sequencer;
    localparam int RST_HOLD = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dl_sequencer_if #(.ROM_AW(17)) bus ();

    dl_sequencer #(.ROM_AW(17), .FIFO_DEPTH(4), .RST_HOLD(RST_HOLD)) dut (
        .clk_sys (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_xfer   = 0;
    logic wait_seen = 1'b0;
    logic [24:0] xq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only move 1 time unit after a rising edge, so the negedge view equals the next edge's.
    always @(negedge clk) begin
        if (rst_n && bus.rom_wr_en && bus.rom_wr_ready) begin
            xq.push_back({bus.rom_wr_addr, bus.rom_wr_data});
            last_xfer = cyc + 1;
        end
        if (bus.ioctl_wait) wait_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] idx, input logic [24:0] addr,
                           input logic [7:0] data, input bit honor);
        int g = 0;
        while (honor && bus.ioctl_wait && g < 100) begin
            tick();
            g++;
        end
        if (g == 100) begin
            vectors++; miscompares++;
            $display("FAIL wait_timeout: ioctl_wait=%b, required 0", bus.ioctl_wait);
        end
        bus.ioctl_index = idx;
        bus.ioctl_addr  = addr;
        bus.ioctl_dout  = data;
        bus.ioctl_wr    = 1'b1;
        tick();
        bus.ioctl_wr    = 1'b0;
    endtask

    task automatic wait_run(output int fall);
        int n = 0;
        while (bus.core_reset && n < 1000) begin
            tick();
            n++;
        end
        if (bus.core_reset) begin
            vectors++; miscompares++;
            $display("FAIL run_timeout: core_reset=%b, required 0", bus.core_reset);
        end
        fall = cyc;
    endtask

    task automatic test_reset();
        int n = 0;
        rst_n = 1'b0;
        bus.ioctl_download = 0; bus.ioctl_wr = 0; bus.ioctl_addr = '0;
        bus.ioctl_dout = '0; bus.ioctl_index = '0; bus.rom_wr_ready = 1'b1;
        repeat (3) tick();
        vectors += 7;
        if (bus.core_reset !== 1'b1) begin miscompares++; $display("FAIL rst_core_reset: got %b, required 1", bus.core_reset); end
        if (bus.ioctl_wait !== 1'b0) begin miscompares++; $display("FAIL rst_wait: got %b, required 0", bus.ioctl_wait); end
        if (bus.rom_wr_en !== 1'b0)  begin miscompares++; $display("FAIL rst_wr_en: got %b, required 0", bus.rom_wr_en); end
        if (bus.load_done !== 1'b0)  begin miscompares++; $display("FAIL rst_load_done: got %b, required 0", bus.load_done); end
        if (bus.err_overrun !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b, required 0", bus.err_overrun); end
        if (bus.tno !== 4'h0)        begin miscompares++; $display("FAIL rst_tno: got %h, required 0", bus.tno); end
        if (bus.dsw !== 24'h0)       begin miscompares++; $display("FAIL rst_dsw: got %h, required 0", bus.dsw); end
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (!bus.core_reset) break;
            n++;
        end
        vectors += 2;
        if (n != RST_HOLD) begin miscompares++; $display("FAIL rst_hold_len: got %0d, required %0d", n, RST_HOLD); end
        if (bus.load_done !== 1'b1) begin miscompares++; $display("FAIL rst_run: load_done=%b, required 1", bus.load_done); end
    endtask

    task automatic test_stream();
        int fall;
        xq.delete(); wait_seen = 1'b0; bus.rom_wr_ready = 1'b1;
        bus.ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) wr_byte(8'd0, 25'(i), 8'(i) ^ 8'hA5, 1'b1);
        bus.ioctl_download = 1'b0;
        wait_run(fall);
        vectors++;
        if (xq.size() != 16) begin miscompares++; $display("FAIL stream_count: got %0d, required 16", xq.size()); end
        for (int i = 0; i < 16 && i < xq.size(); i++) begin
            vectors++;
            if (xq[i] !== {17'(i), 8'(i) ^ 8'hA5}) begin
                miscompares++; $display("FAIL stream_order[%0d]: got %h, required %h", i, xq[i], {17'(i), 8'(i) ^ 8'hA5});
            end
        end
        vectors += 3;
        if (wait_seen !== 1'b0) begin miscompares++; $display("FAIL stream_wait: got %b, required 0", wait_seen); end
        if (bus.err_overrun !== 1'b0) begin miscompares++; $display("FAIL stream_err: got %b, required 0", bus.err_overrun); end
        // last transfer in LOAD, one DRAIN cycle, RST_HOLD HOLD cycles, one registered-output cycle
        if (fall - last_xfer != RST_HOLD + 2) begin
            miscompares++; $display("FAIL stream_release: got %0d, required %0d", fall - last_xfer, RST_HOLD + 2);
        end
    endtask

    task automatic test_backpressure();
        int fall;
        xq.delete(); bus.rom_wr_ready = 1'b0;
        bus.ioctl_download = 1'b1;
        tick();
        wr_byte(8'd0, 25'd0, 8'h00 ^ 8'hA5, 1'b1);
        wr_byte(8'd0, 25'd1, 8'h01 ^ 8'hA5, 1'b1);
        vectors++;
        if (bus.ioctl_wait !== 1'b0) begin miscompares++; $display("FAIL bp_wait_2: got %b, required 0", bus.ioctl_wait); end
        wr_byte(8'd0, 25'd2, 8'h02 ^ 8'hA5, 1'b1);
        vectors++;
        if (bus.ioctl_wait !== 1'b1) begin miscompares++; $display("FAIL bp_wait_3: got %b, required 1", bus.ioctl_wait); end
        wr_byte(8'd0, 25'd3, 8'h03 ^ 8'hA5, 1'b0);
        vectors++;
        if (bus.err_overrun !== 1'b0) begin miscompares++; $display("FAIL bp_err_slack: got %b, required 0", bus.err_overrun); end
        wr_byte(8'd0, 25'd16, 8'hEE, 1'b0);
        vectors++;
        if (bus.err_overrun !== 1'b1) begin miscompares++; $display("FAIL bp_err_set: got %b, required 1", bus.err_overrun); end
        repeat (5) tick();
        bus.rom_wr_ready = 1'b1;
        wr_byte(8'd0, 25'd4, 8'h04 ^ 8'hA5, 1'b0);
        for (int i = 5; i < 16; i++) wr_byte(8'd0, 25'(i), 8'(i) ^ 8'hA5, 1'b1);
        bus.ioctl_download = 1'b0;
        wait_run(fall);
        vectors += 2;
        if (xq.size() != 16) begin miscompares++; $display("FAIL bp_count: got %0d, required 16", xq.size()); end
        if (bus.err_overrun !== 1'b1) begin miscompares++; $display("FAIL bp_err_sticky: got %b, required 1", bus.err_overrun); end
        for (int i = 0; i < 16 && i < xq.size(); i++) begin
            vectors++;
            if (xq[i] !== {17'(i), 8'(i) ^ 8'hA5}) begin
                miscompares++; $display("FAIL bp_order[%0d]: got %h, required %h", i, xq[i], {17'(i), 8'(i) ^ 8'hA5});
            end
        end
    endtask

    task automatic test_drain_edge();
        int fall;
        xq.delete(); bus.rom_wr_ready = 1'b0;
        bus.ioctl_download = 1'b1;
        tick();
        wr_byte(8'd0, 25'h20, 8'h20 ^ 8'hA5, 1'b1);
        wr_byte(8'd0, 25'h21, 8'h21 ^ 8'hA5, 1'b1);
        bus.ioctl_download = 1'b0;
        repeat (3) tick();
        vectors += 3;
        if (bus.core_reset !== 1'b1) begin miscompares++; $display("FAIL drain_reset: got %b, required 1", bus.core_reset); end
        if (bus.rom_wr_en !== 1'b1)  begin miscompares++; $display("FAIL drain_wr_en: got %b, required 1", bus.rom_wr_en); end
        if (bus.err_overrun !== 1'b0) begin miscompares++; $display("FAIL drain_err_clear: got %b, required 0", bus.err_overrun); end
        bus.rom_wr_ready = 1'b1;
        wait_run(fall);
        vectors += 2;
        if (xq.size() != 2) begin miscompares++; $display("FAIL drain_count: got %0d, required 2", xq.size()); end
        // HOLD begins on the last transfer's own edge
        if (fall - last_xfer != RST_HOLD + 1) begin
            miscompares++; $display("FAIL drain_release: got %0d, required %0d", fall - last_xfer, RST_HOLD + 1);
        end
    endtask

    task automatic test_config();
        int fall;
        xq.delete(); bus.rom_wr_ready = 1'b1;
        bus.ioctl_download = 1'b1;
        tick();
        wr_byte(8'd1, 25'd0, 8'h03, 1'b1);
        wr_byte(8'd254, 25'd0, 8'h11, 1'b1);
        wr_byte(8'd254, 25'd1, 8'h22, 1'b1);
        wr_byte(8'd254, 25'd2, 8'h33, 1'b1);
        vectors += 2;
        if (bus.tno !== 4'h3)       begin miscompares++; $display("FAIL cfg_tno3: got %h, required 3", bus.tno); end
        if (bus.dsw !== 24'h232211) begin miscompares++; $display("FAIL cfg_dsw3: got %h, required 232211", bus.dsw); end
        wr_byte(8'd1, 25'd0, 8'h02, 1'b1);
        vectors++;
        if (bus.dsw !== 24'h332211) begin miscompares++; $display("FAIL cfg_dsw2: got %h, required 332211", bus.dsw); end
        wr_byte(8'd1, 25'd0, 8'h00, 1'b1);
        vectors++;
        if (bus.dsw !== 24'h332211) begin miscompares++; $display("FAIL cfg_dsw0: got %h, required 332211", bus.dsw); end
        wr_byte(8'd1, 25'd0, 8'hF1, 1'b1);
        vectors += 2;
        if (bus.tno !== 4'h1)       begin miscompares++; $display("FAIL cfg_tno1: got %h, required 1", bus.tno); end
        if (bus.dsw !== 24'h232211) begin miscompares++; $display("FAIL cfg_dsw1: got %h, required 232211", bus.dsw); end
        wr_byte(8'd0, 25'h20000, 8'h77, 1'b1);
        wr_byte(8'd254, 25'd8, 8'h99, 1'b1);
        vectors++;
        if (bus.dsw !== 24'h232211) begin miscompares++; $display("FAIL cfg_dip_addr8: got %h, required 232211", bus.dsw); end
        bus.ioctl_download = 1'b0;
        repeat (2) tick();
        wr_byte(8'd1, 25'd0, 8'h05, 1'b1);
        wr_byte(8'd254, 25'd0, 8'h55, 1'b1);
        wr_byte(8'd0, 25'd5, 8'h66, 1'b1);
        repeat (3) tick();
        vectors += 3;
        if (bus.tno !== 4'h1)       begin miscompares++; $display("FAIL cfg_tno_outside: got %h, required 1", bus.tno); end
        if (bus.dsw !== 24'h232211) begin miscompares++; $display("FAIL cfg_dip_outside: got %h, required 232211", bus.dsw); end
        if (xq.size() != 0)         begin miscompares++; $display("FAIL cfg_rom_writes: got %0d, required 0", xq.size()); end
        wait_run(fall);
    endtask

    task automatic test_redownload();
        int fall;
        bus.rom_wr_ready = 1'b0;
        bus.ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) wr_byte(8'd0, 25'(8'h40 + i), 8'(i), 1'b0);
        bus.rom_wr_ready = 1'b1;
        bus.ioctl_download = 1'b0;
        // four drain edges enter HOLD at 255; 155 more bring the count to 100
        repeat (159) tick();
        vectors += 3;
        if (bus.core_reset !== 1'b1)  begin miscompares++; $display("FAIL redl_hold_reset: got %b, required 1", bus.core_reset); end
        if (bus.load_done !== 1'b0)   begin miscompares++; $display("FAIL redl_hold_done: got %b, required 0", bus.load_done); end
        if (bus.err_overrun !== 1'b1) begin miscompares++; $display("FAIL redl_err_set: got %b, required 1", bus.err_overrun); end
        bus.ioctl_download = 1'b1;
        tick();
        vectors += 2;
        if (bus.err_overrun !== 1'b0) begin miscompares++; $display("FAIL redl_err_clear: got %b, required 0", bus.err_overrun); end
        if (bus.core_reset !== 1'b1)  begin miscompares++; $display("FAIL redl_reset: got %b, required 1", bus.core_reset); end
        xq.delete();
        wr_byte(8'd0, 25'h50, 8'h5A, 1'b1);
        wr_byte(8'd0, 25'h51, 8'h5B, 1'b1);
        bus.ioctl_download = 1'b0;
        wait_run(fall);
        vectors += 2;
        if (xq.size() != 2) begin miscompares++; $display("FAIL redl_count: got %0d, required 2", xq.size()); end
        if (fall - last_xfer != RST_HOLD + 2) begin
            miscompares++; $display("FAIL redl_release: got %0d, required %0d", fall - last_xfer, RST_HOLD + 2);
        end
    endtask

    task automatic test_async_abort();
        bus.rom_wr_ready = 1'b0;
        bus.ioctl_download = 1'b1;
        tick();
        wr_byte(8'd0, 25'd1, 8'h11, 1'b1);
        wr_byte(8'd0, 25'd2, 8'h22, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        vectors += 3;
        if (bus.rom_wr_en !== 1'b0)  begin miscompares++; $display("FAIL abort_wr_en: got %b, required 0", bus.rom_wr_en); end
        if (bus.ioctl_wait !== 1'b0) begin miscompares++; $display("FAIL abort_wait: got %b, required 0", bus.ioctl_wait); end
        if (bus.core_reset !== 1'b1) begin miscompares++; $display("FAIL abort_reset: got %b, required 1", bus.core_reset); end
        bus.ioctl_download = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_drain_edge();
        test_config();
        test_redownload();
        test_async_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
